pc_exc_unit: RTL

PC_EXC_UNIT -- requirements
Module: pc_exc_unit

---
 rtl/pc_exc_if.sv | 31 +++
 rtl/pc_exc_unit.sv | 81 ++++++++
 2 files changed

// File: rtl/pc_exc_if.sv
// Bus bundle between the control/datapath and the PC / exception unit.
interface pc_exc_if;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  branch_type;
  logic        zero;
  logic        gt;
  logic        exc_opcode;
  logic        exc_ovf;
  logic        exc_div0;
  logic [31:0] mem_data;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;
  logic        exc_mem_rd;
  logic        exc_busy;

  modport master (
    output pc_next, pc_write, pc_write_cond, branch_type, zero, gt,
           exc_opcode, exc_ovf, exc_div0, mem_data,
    input  pc, epc, exc_cause, exc_addr, exc_mem_rd, exc_busy
  );

  modport slave (
    input  pc_next, pc_write, pc_write_cond, branch_type, zero, gt,
           exc_opcode, exc_ovf, exc_div0, mem_data,
    output pc, epc, exc_cause, exc_addr, exc_mem_rd, exc_busy
  );
endinterface

// File: rtl/pc_exc_unit.sv
// Program counter with branch evaluation and a vectored exception sequencer
// (capture EPC/cause, fetch vector byte from memory, load it into PC).
module pc_exc_unit (
  input  logic     clk,
  input  logic     reset,
  pc_exc_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXC_ADDR, EXC_WAIT, EXC_LOAD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] epc_q, epc_nxt;
  logic [1:0]  cause_q, cause_nxt;
  logic        cond, take, exc_any;
  logic        unused_mem_bits;

  assign unused_mem_bits = ^bus.mem_data[31:8];

  always_comb begin
    cond = 1'b0;
    unique case (bus.branch_type)
      2'b00: cond = bus.zero;
      2'b01: cond = !bus.zero;
      2'b10: cond = bus.gt;
      2'b11: cond = !bus.gt;
    endcase
  end

  assign take    = bus.pc_write || (bus.pc_write_cond && cond);
  assign exc_any = bus.exc_opcode || bus.exc_ovf || bus.exc_div0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pc_q    <= '0;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      epc_q   <= epc_nxt;
      cause_q <= cause_nxt;
    end
  end

  // Exceptions outrank any PC write in the same cycle; all requests are
  // dropped while the sequencer is busy.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    epc_nxt   = epc_q;
    cause_nxt = cause_q;
    unique case (state)
      IDLE: begin
        if (exc_any) begin
          state_nxt = EXC_ADDR;
          epc_nxt   = pc_q - 32'd4;
          if (bus.exc_opcode)   cause_nxt = 2'b01;
          else if (bus.exc_ovf) cause_nxt = 2'b10;
          else                  cause_nxt = 2'b11;
        end else if (take) begin
          pc_nxt = bus.pc_next;
        end
      end
      EXC_ADDR: state_nxt = EXC_WAIT;
      EXC_WAIT: state_nxt = EXC_LOAD;
      EXC_LOAD: begin
        pc_nxt    = {24'b0, bus.mem_data[7:0]};
        state_nxt = IDLE;
      end
    endcase
  end

  // Vectors 253/254/255 are 0xFC | cause.
  assign bus.exc_addr   = (cause_q == 2'b00) ? '0 : {24'b0, 6'b111111, cause_q};
  assign bus.exc_mem_rd = (state == EXC_ADDR) || (state == EXC_WAIT);
  assign bus.exc_busy   = (state != IDLE);
  assign bus.pc         = pc_q;
  assign bus.epc        = epc_q;
  assign bus.exc_cause  = cause_q;
endmodule
